// File: rtl/quad_decoder_pkg.sv
// Shared constants and helpers for the quadrature decoder.
// Holds state encoding, default filter length and the step table.
package quad_decoder_pkg;

    localparam int FILTER_LEN_DEF = 3;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef struct packed {
        logic up;
        logic bad;
    } move_t;

    // Forward sequence on {A,B}: 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] up_next(input logic [1:0] ab);
        logic [1:0] nx;
        unique case (ab)
            2'b00: nx = 2'b10;
            2'b10: nx = 2'b11;
            2'b11: nx = 2'b01;
            2'b01: nx = 2'b00;
        endcase
        return nx;
    endfunction

    function automatic move_t classify(
        input logic [1:0] prev,
        input logic [1:0] cur
    );
        move_t m;
        m.bad = &(prev ^ cur);
        m.up  = (cur == up_next(prev));
        return m;
    endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter.
// valid rises once the filter has seen a settled input after reset.
module quad_sync_filter
    import quad_decoder_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic filt,
    output logic valid
);

    localparam logic [3:0] LEN  = 4'(FILTER_LEN);
    localparam logic [4:0] WARM = 5'(FILTER_LEN + 2);

    logic       s1;
    logic       s2;
    logic [3:0] run;
    logic [4:0] age;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            run  <= '0;
            filt <= 1'b0;
            age  <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            if (age != WARM)
                age <= age + 5'd1;
            // the sample seen on the flip edge already counts against the new level
            if (run == LEN) begin
                filt <= ~filt;
                run  <= (s2 == filt) ? 4'd1 : 4'd0;
            end else if (s2 != filt) begin
                run <= run + 4'd1;
            end else begin
                run <= '0;
            end
        end
    end

    assign valid = (age == WARM) && (run == '0);

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B into up/down step pulses.
// Double-bit jumps are flagged and counted instead of stepped.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       dec_en,
    input  logic       clr_err,
    output logic       enable,
    output logic       upDown,
    output logic       err,
    output logic [3:0] err_cnt
);

    logic       fa;
    logic       fb;
    logic       va;
    logic       vb;
    logic       state;
    logic [1:0] prev;
    logic [1:0] cur;
    logic       moved;
    logic       bad_step;
    move_t      mv;

    quad_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_a (
        .clk   (clk),
        .rst   (rst),
        .d     (a_in),
        .filt  (fa),
        .valid (va)
    );

    quad_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_b (
        .clk   (clk),
        .rst   (rst),
        .d     (b_in),
        .filt  (fb),
        .valid (vb)
    );

    assign cur      = {fa, fb};
    assign mv       = classify(prev, cur);
    assign moved    = (state == ST_RUN) && (cur != prev);
    assign bad_step = moved && mv.bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_INIT;
            prev   <= '0;
            enable <= 1'b0;
            upDown <= 1'b1;
            err    <= 1'b0;
        end else begin
            enable <= 1'b0;
            err    <= 1'b0;
            unique case (state)
                ST_INIT: begin
                    if (va && vb) begin
                        prev  <= cur;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (moved) begin
                        prev <= cur;
                        if (mv.bad) begin
                            err <= 1'b1;
                        end else if (dec_en) begin
                            enable <= 1'b1;
                            upDown <= mv.up;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_cnt <= '0;
        else if (clr_err)
            err_cnt <= '0;
        else if (bad_step && err_cnt != 4'hF)
            err_cnt <= err_cnt + 4'd1;
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder with a sliding-window model.
// Directed scenarios followed by randomized A/B activity.
module tb_quad_decoder;

    localparam int FL = 3;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       a_in    = 1'b0;
    logic       b_in    = 1'b0;
    logic       dec_en  = 1'b1;
    logic       clr_err = 1'b0;
    logic       enable;
    logic       upDown;
    logic       err;
    logic [3:0] err_cnt;

    int n_chk = 0;
    int n_err = 0;

    int         e;
    logic       ha [64];
    logic       hb [64];
    logic       fa_m;
    logic       fb_m;
    logic [1:0] prev_m;
    logic       exp_en;
    logic       exp_up;
    logic       exp_err;
    logic [3:0] cnt_m;

    int         n_en;
    int         n_up;
    int         n_dn;
    int         n_bad;
    logic [3:0] ctr;

    quad_decoder #(.FILTER_LEN(FL)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_in    (a_in),
        .b_in    (b_in),
        .dec_en  (dec_en),
        .clr_err (clr_err),
        .enable  (enable),
        .upDown  (upDown),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Position on the forward cycle 00,10,11,01
    function automatic int gpos(input logic [1:0] v);
        int p;
        case (v)
            2'b00:   p = 0;
            2'b10:   p = 1;
            2'b11:   p = 2;
            default: p = 3;
        endcase
        return p;
    endfunction

    // Filtered level = value of the last FL settled samples if they agree
    function automatic logic win(input bit chb, input logic cur_v);
        logic first;
        logic v;
        bit   same;
        first = 1'b0;
        same  = 1'b1;
        for (int j = e - 2 - FL; j <= e - 3; j++) begin
            if (j < 1)
                v = 1'b0;
            else
                v = chb ? hb[j % 64] : ha[j % 64];
            if (j == e - 2 - FL)
                first = v;
            else if (v !== first)
                same = 1'b0;
        end
        return same ? first : cur_v;
    endfunction

    task automatic model_reset();
        e       = 0;
        fa_m    = 1'b0;
        fb_m    = 1'b0;
        prev_m  = 2'b00;
        exp_en  = 1'b0;
        exp_up  = 1'b1;
        exp_err = 1'b0;
        cnt_m   = 4'd0;
    endtask

    task automatic model_edge();
        logic [1:0] cur;
        int         d;
        if (!rst) begin
            model_reset();
            return;
        end
        cur = {fa_m, fb_m};
        e++;
        ha[e % 64] = a_in;
        hb[e % 64] = b_in;
        exp_en  = 1'b0;
        exp_err = 1'b0;
        if (e == FL + 4) begin
            prev_m = cur;
        end else if (e > FL + 4 && cur != prev_m) begin
            d = (gpos(cur) - gpos(prev_m) + 4) % 4;
            if (d == 2) begin
                exp_err = 1'b1;
            end else if (dec_en) begin
                exp_en = 1'b1;
                exp_up = (d == 1);
            end
            prev_m = cur;
        end
        if (clr_err)
            cnt_m = 4'd0;
        else if (exp_err && cnt_m < 4'd15)
            cnt_m = cnt_m + 4'd1;
        fa_m = win(1'b0, fa_m);
        fb_m = win(1'b1, fb_m);
    endtask

    task automatic compare();
        if (!rst)
            return;
        chk("enable",  32'(enable),  32'(exp_en));
        chk("upDown",  32'(upDown),  32'(exp_up));
        chk("err",     32'(err),     32'(exp_err));
        chk("err_cnt", 32'(err_cnt), 32'(cnt_m));
        if (enable) begin
            n_en++;
            if (upDown) begin
                n_up++;
                ctr = ctr + 4'd1;
            end else begin
                n_dn++;
                ctr = ctr - 4'd1;
            end
        end
        if (err)
            n_bad++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic step(input logic [1:0] ab, input int n);
        a_in = ab[1];
        b_in = ab[0];
        hold(n);
    endtask

    task automatic clear_counts();
        n_en  = 0;
        n_up  = 0;
        n_dn  = 0;
        n_bad = 0;
        ctr   = 4'd0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        chk("rst_enable",  32'(enable),  0);
        chk("rst_upDown",  32'(upDown),  1);
        chk("rst_err",     32'(err),     0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        model_reset();
        repeat (n) tick();
        rst = 1'b1;
    endtask

    initial begin
        int lat;
        logic [1:0] ab;
        clear_counts();
        model_reset();
        #2;

        a_in = 1'b1;
        b_in = 1'b1;
        do_reset(4);
        hold(12);
        chk("init_enable", n_en, 0);
        chk("init_err", n_bad, 0);

        step(2'b01, 10);
        step(2'b00, 10);
        chk("prime_11_up", n_up, 2);

        clear_counts();
        step(2'b10, 10);
        step(2'b11, 10);
        step(2'b01, 10);
        step(2'b00, 10);
        chk("fwd_pulses", n_en, 4);
        chk("fwd_ctr", 32'(ctr), 4);

        a_in = 1'b1;
        lat  = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (enable && lat == 99)
                lat = i;
        end
        chk("latency", lat, FL + 4);
        step(2'b00, 10);

        clear_counts();
        step(2'b01, 10);
        step(2'b11, 10);
        step(2'b10, 10);
        step(2'b00, 10);
        chk("rev_pulses", n_dn, 4);
        chk("rev_ctr", 32'(ctr), 12);
        chk("rev_dir", 32'(upDown), 0);

        clear_counts();
        step(2'b10, 2);
        step(2'b00, 12);
        chk("glitch2_en", n_en, 0);
        chk("glitch2_err", n_bad, 0);
        step(2'b10, 3);
        step(2'b00, 14);
        chk("glitch3_up", n_up, 1);
        chk("glitch3_dn", n_dn, 1);

        clear_counts();
        for (int i = 0; i < 16; i++)
            step((i % 2 == 0) ? 2'b11 : 2'b00, 10);
        chk("bad_pulses", n_bad, 16);
        chk("bad_enable", n_en, 0);
        chk("bad_sat", 32'(err_cnt), 15);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_cnt", 32'(err_cnt), 0);

        step(2'b11, 6);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_coinc_err", 32'(err), 1);
        chk("clr_coinc_cnt", 32'(err_cnt), 0);
        step(2'b01, 10);
        step(2'b00, 10);

        clear_counts();
        a_in = 1'b1;
        hold(2);
        do_reset(3);
        hold(12);
        dec_en = 1'b0;
        step(2'b11, 10);
        chk("mid_enable", n_en, 0);
        chk("mid_err", n_bad, 0);
        dec_en = 1'b1;
        step(2'b01, 10);
        chk("resume_en", n_up, 1);
        chk("resume_err", n_bad, 0);

        a_in = 1'b0;
        b_in = 1'b0;
        do_reset(3);
        hold(12);
        repeat (300) begin
            ab     = 2'($urandom_range(0, 3));
            dec_en = ($urandom_range(0, 3) != 0);
            a_in   = ab[1];
            b_in   = ab[0];
            repeat ($urandom_range(1, 12)) begin
                clr_err = ($urandom_range(0, 15) == 0);
                tick();
            end
            clr_err = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 3: consecutive identical synchronized samples required before a filtered channel changes (legal 2..15).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 a_in  input  1  quadrature channel A, asynchronous to clk.
REQ-005 b_in  input  1  quadrature channel B, asynchronous to clk.
REQ-006 dec_en  input  1  decode enable; 0 suppresses step pulses, tracking continues.
REQ-007 clr_err  input  1  synchronous clear of err_cnt.
REQ-008 enable  output  1  one-cycle step pulse, drives the downstream up/down counter enable.
REQ-009 upDown  output  1  step direction, 1 = up, 0 = down, drives the downstream counter upDown.
REQ-010 err  output  1  one-cycle pulse on illegal (double-bit) transition.
REQ-011 err_cnt  output  4  saturating count of illegal transitions.

Function
REQ-012 Each channel SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL have a filter: a sample differing from the filtered value increments a run counter; a matching sample clears it; the filtered value takes the sample when the counter reaches FILTER_LEN.
REQ-014 Any run shorter than FILTER_LEN samples SHALL be discarded with no output effect.
REQ-015 The decoder SHALL be a 2-state FSM: INIT, RUN.
REQ-016 In INIT, once both filters report a stable value (FILTER_LEN samples since reset), prev = {A,B} filtered SHALL be loaded, no pulse is generated, and the FSM moves to RUN.
REQ-017 In RUN, the up sequence {A,B} SHALL be 00->10->11->01->00 and the down sequence its reverse.
REQ-018 A single-bit change on the up sequence SHALL give enable=1 and upDown=1 for exactly one cycle.
REQ-019 A single-bit change on the down sequence SHALL give enable=1 and upDown=0 for exactly one cycle.
REQ-020 upDown SHALL hold its last value between pulses; the counter samples it with enable on the same edge.
REQ-021 A simultaneous change of both filtered bits SHALL give err=1 for one cycle, enable=0, upDown unchanged, prev updated, err_cnt+1 saturating at 15.
REQ-022 With dec_en=0, prev SHALL still update, enable SHALL stay 0, and err/err_cnt SHALL operate normally.
REQ-023 clr_err=1 SHALL zero err_cnt on the next edge; if coincident with an illegal transition, err_cnt SHALL be 0 and err still pulses.
REQ-024 Latency: an input level first sampled at edge N SHALL produce enable high after edge N+FILTER_LEN+3 (edge N+6 at default).
REQ-025 Every output SHALL be registered; no combinational path from an input to an output.
REQ-026 At most one pulse SHALL occur per filtered transition; back-to-back legal transitions SHALL give consecutive pulses with no loss.

Reset
REQ-027 rst=0 SHALL immediately force enable=0, upDown=1, err=0, err_cnt=0, FSM=INIT, filters, run counters and synchronizers to 0.
REQ-028 Reset mid-run SHALL discard partial filter runs; after release the block SHALL re-prime through INIT with no spurious pulse or error.

Structure
REQ-029 The FSM state encoding, the FILTER_LEN default and the legal-transition table SHALL be shared constants in the project package/include.
REQ-030 One sub-module, quad_sync_filter (synchronizer plus filter, one per channel), SHALL be instantiated twice.

Verification (FILTER_LEN=3)
REQ-031 Reset: hold rst=0 with a_in=b_in=1 -> all outputs at reset values; release -> INIT primes to 11, no enable, no err.
REQ-032 Forward: 00->10->11->01->00, each held 10 cycles -> 4 enable pulses, upDown=1, each 6 edges after change; downstream counter reads 4.
REQ-033 Reverse: 00->01->11->10->00 -> 4 pulses with upDown=0; counter goes 0 -> 12 (wrap).
REQ-034 Glitch: a_in high for 2 cycles then back -> no enable, no err; a 3-cycle pulse -> exactly 1 enable, later 1 reverse enable.
REQ-035 Illegal: 00->11 repeated 16 times -> 16 err pulses, no enable, err_cnt saturates at 15; clr_err=1 -> err_cnt=0 next cycle.
REQ-036 Mid-operation: rst=0 during a filter run, with dec_en=0 for one transition -> no pulse during either, counting resumes correctly afterward.
